// File: rtl/isa_capture_uart_dumper.sv
// isa_capture_uart_dumper
//   Drains the ISA bus capture buffer once it reports Ready. Each 26-bit record
//   is fetched with a single ReadClock pulse, then sent to the host over an
//   8N1 UART as a self-synchronising 4-byte frame. Only the first byte of a
//   frame has bit 7 set, so the host can realign after any dropped byte.
//
// Ports:
//   Clock50MHz  in   system clock
//   Reset       in   asynchronous, active-high
//   Ready       in   capture buffer full and readable
//   MemData     in   capture buffer read data (26 bits)
//   ReadClock   out  capture buffer read clock; falling edge advances address
//   Tx          out  UART serial output, idle high
//   Busy        out  dump in progress
//   Done        out  all DEPTH records sent; held until Ready falls
//   WordCount   out  index of the record currently being sent
//
// State table:
//   IDLE  | waiting for Ready
//   RD_HI | ReadClock high, buffer registering address (two cycles)
//   LATCH | ReadClock high, MemData captured into word register
//   RD_LO | ReadClock low, upstream address advances; UART start is loaded
//   SEND  | shifting the 4-byte frame out on Tx
//   NEXT  | terminal record check / WordCount increment
//   DONE  | all records sent, waiting for Ready to fall

module isa_capture_uart_dumper #(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 115200,
  parameter int DEPTH  = 4096,
  parameter int AW     = 12
) (
  input  logic          Clock50MHz,
  input  logic          Reset,
  input  logic          Ready,
  input  logic [25:0]   MemData,
  output logic          ReadClock,
  output logic          Tx,
  output logic          Busy,
  output logic          Done,
  output logic [AW-1:0] WordCount
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int BW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [BW-1:0] DIV_M1 = BW'(DIV - 1);
  localparam logic [AW-1:0] LAST   = AW'(DEPTH - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RD_HI = 3'd1;
  localparam logic [2:0] S_LATCH = 3'd2;
  localparam logic [2:0] S_RD_LO = 3'd3;
  localparam logic [2:0] S_SEND  = 3'd4;
  localparam logic [2:0] S_NEXT  = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  logic [2:0]    state_q,    state_d;
  logic          rd_wait_q,  rd_wait_d;
  logic [25:0]   word_q,     word_d;
  logic [8:0]    shift_q,    shift_d;
  logic [3:0]    bit_idx_q,  bit_idx_d;
  logic [1:0]    byte_idx_q, byte_idx_d;
  logic [BW-1:0] baud_q,     baud_d;
  logic          abort_q,    abort_d;
  logic          tx_q,       tx_d;
  logic          rclk_q,     rclk_d;
  logic          busy_q,     busy_d;
  logic          done_q,     done_d;
  logic [AW-1:0] wcnt_q,     wcnt_d;
  logic          last_rec;

  function automatic logic [7:0] frame_byte(input logic [25:0] w, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = {3'b100, w[25:21]};
      2'd1:    b = {1'b0, w[20:14]};
      2'd2:    b = {1'b0, w[13:7]};
      default: b = {1'b0, w[6:0]};
    endcase
    return b;
  endfunction

  always_comb begin
    state_d    = state_q;
    rd_wait_d  = rd_wait_q;
    word_d     = word_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    baud_d     = baud_q;
    abort_d    = abort_q;
    tx_d       = tx_q;
    wcnt_d     = wcnt_q;

    case (state_q)
      S_IDLE: begin
        abort_d = 1'b0;
        if (Ready) begin
          state_d   = S_RD_HI;
          rd_wait_d = 1'b0;
        end
      end
      S_RD_HI: begin
        if (!Ready) state_d = S_IDLE;
        else if (rd_wait_q) state_d = S_LATCH;
        else rd_wait_d = 1'b1;
      end
      S_LATCH: begin
        if (!Ready) state_d = S_IDLE;
        else begin
          word_d  = MemData;
          state_d = S_RD_LO;
        end
      end
      S_RD_LO: begin
        if (!Ready) state_d = S_IDLE;
        else begin
          state_d    = S_SEND;
          tx_d       = 1'b0;
          shift_d    = {1'b1, frame_byte(word_q, 2'd0)};
          bit_idx_d  = 4'd0;
          byte_idx_d = 2'd0;
          baud_d     = DIV_M1;
          abort_d    = 1'b0;
        end
      end
      S_SEND: begin
        // A falling Ready is remembered so the current byte still finishes
        // cleanly even if Ready comes back before the stop bit ends.
        if (!Ready) abort_d = 1'b1;
        if (baud_q != '0) begin
          baud_d = baud_q - BW'(1);
        end else if (bit_idx_q == 4'd9) begin
          if (abort_q || !Ready) state_d = S_IDLE;
          else if (byte_idx_q == 2'd3) state_d = S_NEXT;
          else begin
            byte_idx_d = byte_idx_q + 2'd1;
            tx_d       = 1'b0;
            shift_d    = {1'b1, frame_byte(word_q, byte_idx_q + 2'd1)};
            bit_idx_d  = 4'd0;
            baud_d     = DIV_M1;
          end
        end else begin
          tx_d      = shift_q[0];
          shift_d   = {1'b1, shift_q[8:1]};
          bit_idx_d = bit_idx_q + 4'd1;
          baud_d    = DIV_M1;
        end
      end
      S_NEXT: begin
        // All records are already on the wire at this point, so the terminal
        // case completes even if Ready is dropping.
        if (wcnt_q == LAST) state_d = S_DONE;
        else if (!Ready) state_d = S_IDLE;
        else begin
          wcnt_d    = wcnt_q + AW'(1);
          state_d   = S_RD_HI;
          rd_wait_d = 1'b0;
        end
      end
      S_DONE: begin
        if (!Ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_IDLE) wcnt_d = '0;
    if (state_d != S_SEND) tx_d = 1'b1;
  end

  // Busy/Done look one state ahead so they change in the first cycle after
  // the final stop bit, not one cycle later when NEXT resolves.
  assign last_rec = (state_d == S_NEXT) && (wcnt_q == LAST);
  assign rclk_d   = (state_d == S_RD_HI) || (state_d == S_LATCH);
  assign done_d   = (state_d == S_DONE) || last_rec;
  assign busy_d   = (state_d != S_IDLE) && (state_d != S_DONE) && !last_rec;

  always_ff @(posedge Clock50MHz or posedge Reset) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      rd_wait_q  <= 1'b0;
      word_q     <= '0;
      shift_q    <= '1;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      baud_q     <= '0;
      abort_q    <= 1'b0;
      tx_q       <= 1'b1;
      rclk_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      rd_wait_q  <= rd_wait_d;
      word_q     <= word_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      baud_q     <= baud_d;
      abort_q    <= abort_d;
      tx_q       <= tx_d;
      rclk_q     <= rclk_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      wcnt_q     <= wcnt_d;
    end
  end

  assign ReadClock = rclk_q;
  assign Tx        = tx_q;
  assign Busy      = busy_q;
  assign Done      = done_q;
  assign WordCount = wcnt_q;

endmodule

// File: tb/tb_isa_capture_uart_dumper.sv
module tb_isa_capture_uart_dumper;

  localparam int SDIV    = 4;          // 1000 / 230 truncated
  localparam int SFRAME  = 40 * SDIV;
  localparam int DDIV    = 434;        // 50 MHz / 115200 truncated
  localparam int DFRAME  = 40 * DDIV;

  logic        clk = 1'b0;
  always #10 clk = ~clk;

  logic        Reset, Ready, Ready_def;
  logic [25:0] MemData, MemData_def;
  logic        ReadClock, Tx, Busy, Done;
  logic [1:0]  WordCount;
  logic        ReadClock_def, Tx_def, Busy_def, Done_def;
  logic [11:0] WordCount_def;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  isa_capture_uart_dumper #(.CLK_HZ(1000), .BAUD(230), .DEPTH(4), .AW(2)) u_dut (
    .Clock50MHz(clk), .Reset(Reset), .Ready(Ready), .MemData(MemData),
    .ReadClock(ReadClock), .Tx(Tx), .Busy(Busy), .Done(Done), .WordCount(WordCount)
  );

  isa_capture_uart_dumper u_dut_def (
    .Clock50MHz(clk), .Reset(Reset), .Ready(Ready_def), .MemData(MemData_def),
    .ReadClock(ReadClock_def), .Tx(Tx_def), .Busy(Busy_def), .Done(Done_def),
    .WordCount(WordCount_def)
  );

  // Capture buffer model: registers data on ReadClock rise, advances on fall.
  logic [25:0] mem [0:3];
  logic [1:0]  mem_addr;
  always @(posedge ReadClock) MemData <= mem[mem_addr];
  always @(negedge ReadClock or posedge Reset)
    if (Reset) mem_addr <= 2'd0;
    else mem_addr <= mem_addr + 2'd1;

  // Reference frame: first byte flagged with bit 7, then three 7-bit groups.
  function automatic logic [7:0] model_byte(input logic [25:0] w, input int i);
    int v;
    if (i == 0) v = 128 + int'(w >> 21);
    else v = int'(w >> (7 * (3 - i))) % 128;
    return 8'(v);
  endfunction

  // UART receiver sampling mid-bit on the small-divider instance.
  logic [7:0] rx_q[$];
  int rx_stop_err = 0;
  initial begin : rx_mon
    logic prev;
    logic [7:0] b;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (prev === 1'b1 && Tx === 1'b0) begin
        repeat (SDIV / 2) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
          repeat (SDIV) @(negedge clk);
          b[k] = Tx;
        end
        repeat (SDIV) @(negedge clk);
        if (Tx !== 1'b1) rx_stop_err++;
        rx_q.push_back(b);
      end
      prev = Tx;
    end
  end

  int rc_pulses = 0;
  initial begin : rc_mon
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (ReadClock === 1'b1 && prev !== 1'b1) rc_pulses++;
      prev = ReadClock;
    end
  end

  task automatic do_reset();
    Reset = 1'b1;
    Ready = 1'b0;
    Ready_def = 1'b0;
    repeat (3) @(negedge clk);
    Reset = 1'b0;
    repeat (50) @(negedge clk);
    rx_q.delete();
    rx_stop_err = 0;
    rc_pulses = 0;
  endtask

  task automatic test_reset();
    int t;
    @(negedge clk);
    checks++;
    if (Tx !== 1'b1 || ReadClock !== 1'b0 || Busy !== 1'b0 || Done !== 1'b0 || WordCount !== 2'd0) begin
      errors++;
      $display("FAIL reset_initial: got Tx=%b RC=%b Busy=%b Done=%b WC=%0d required 1 0 0 0 0",
               Tx, ReadClock, Busy, Done, WordCount);
    end
    do_reset();
    for (int i = 0; i < 4; i++) mem[i] = 26'($urandom);
    Ready = 1'b1;
    t = 0;
    while (Tx !== 1'b0 && t < 200) begin @(negedge clk); t++; end
    checks++;
    if (t >= 200) begin errors++; $display("FAIL reset_wait_start: timeout waiting for start bit"); end
    @(negedge clk);
    checks++;
    if (Busy !== 1'b1 || Tx !== 1'b0) begin
      errors++;
      $display("FAIL reset_pre: got Busy=%b Tx=%b required 1 0", Busy, Tx);
    end
    #3 Reset = 1'b1;
    #1;
    checks++;
    if (Tx !== 1'b1) begin errors++; $display("FAIL reset_async_tx: got %b required 1", Tx); end
    checks++;
    if (ReadClock !== 1'b0 || Busy !== 1'b0 || Done !== 1'b0 || WordCount !== 2'd0) begin
      errors++;
      $display("FAIL reset_async_outs: got RC=%b Busy=%b Done=%b WC=%0d required 0 0 0 0",
               ReadClock, Busy, Done, WordCount);
    end
    do_reset();
  endtask

  task automatic test_dump(input logic [25:0] w0, input logic [25:0] w1,
                           input logic [25:0] w2, input logic [25:0] w3, input string tag);
    int t, w, s_last, fall_t, bad;
    do_reset();
    mem[0] = w0; mem[1] = w1; mem[2] = w2; mem[3] = w3;
    Ready = 1'b1;
    fall_t = 0;
    s_last = 0;
    for (int r = 0; r < 4; r++) begin
      t = 0;
      while (ReadClock !== 1'b1 && t < 2000) begin @(negedge clk); t++; end
      checks++;
      if (t >= 2000) begin errors++; $display("FAIL %s_rc_timeout: record %0d no ReadClock", tag, r); end
      if (r > 0) begin
        checks++;
        if (cyc - fall_t < SFRAME) begin
          errors++;
          $display("FAIL %s_rc_low: record %0d low time %0d required >= %0d", tag, r, cyc - fall_t, SFRAME);
        end
      end
      checks++;
      if (WordCount !== 2'(r)) begin
        errors++;
        $display("FAIL %s_wordcount: got %0d required %0d", tag, WordCount, r);
      end
      w = 0;
      while (ReadClock === 1'b1 && w < 100) begin w++; @(negedge clk); end
      fall_t = cyc;
      checks++;
      if (w != 3) begin errors++; $display("FAIL %s_rc_width: record %0d got %0d required 3", tag, r, w); end
      t = 0;
      while (Tx !== 1'b0 && t < 20) begin @(negedge clk); t++; end
      s_last = cyc;
      checks++;
      if (t >= 20 || Busy !== 1'b1) begin
        errors++;
        $display("FAIL %s_send_start: record %0d wait=%0d Busy=%b required start bit with Busy=1", tag, r, t, Busy);
      end
    end
    t = 0;
    while (Done !== 1'b1 && t < SFRAME + 20) begin @(negedge clk); t++; end
    checks++;
    if (cyc - s_last != SFRAME) begin
      errors++;
      $display("FAIL %s_done_time: got %0d clocks after last start required %0d", tag, cyc - s_last, SFRAME);
    end
    checks++;
    if (Busy !== 1'b0 || Tx !== 1'b1 || WordCount !== 2'd3) begin
      errors++;
      $display("FAIL %s_done_outs: got Busy=%b Tx=%b WC=%0d required 0 1 3", tag, Busy, Tx, WordCount);
    end
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (Done !== 1'b1 || ReadClock !== 1'b0 || Tx !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0 || rc_pulses != 4) begin
      errors++;
      $display("FAIL %s_done_hold: got %0d bad cycles, %0d pulses required 0 and 4", tag, bad, rc_pulses);
    end
    checks++;
    if (rx_q.size() != 16 || rx_stop_err != 0) begin
      errors++;
      $display("FAIL %s_byte_count: got %0d bytes, %0d stop errors required 16 and 0", tag, rx_q.size(), rx_stop_err);
    end
    for (int i = 0; i < 16 && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== model_byte(mem[i / 4], i % 4)) begin
        errors++;
        $display("FAIL %s_byte%0d: got %02h required %02h", tag, i, rx_q[i], model_byte(mem[i / 4], i % 4));
      end
    end
    Ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (Done !== 1'b0 || Busy !== 1'b0 || WordCount !== 2'd0) begin
      errors++;
      $display("FAIL %s_release: got Done=%b Busy=%b WC=%0d required 0 0 0", tag, Done, Busy, WordCount);
    end
  endtask

  task automatic test_abort_read();
    int t;
    do_reset();
    for (int i = 0; i < 4; i++) mem[i] = 26'($urandom);
    Ready = 1'b1;
    t = 0;
    while (ReadClock !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    Ready = 1'b0;
    @(negedge clk);
    checks++;
    if (t >= 50 || ReadClock !== 1'b0 || Busy !== 1'b0 || WordCount !== 2'd0) begin
      errors++;
      $display("FAIL abort_read: got wait=%0d RC=%b Busy=%b WC=%0d required RC=0 Busy=0 WC=0",
               t, ReadClock, Busy, WordCount);
    end
    repeat (60) @(negedge clk);
    checks++;
    if (rc_pulses != 1 || rx_q.size() != 0 || Tx !== 1'b1) begin
      errors++;
      $display("FAIL abort_read_quiet: got pulses=%0d bytes=%0d Tx=%b required 1 0 1", rc_pulses, rx_q.size(), Tx);
    end
  endtask

  task automatic test_abort_send();
    int t, bad;
    do_reset();
    for (int i = 0; i < 4; i++) mem[i] = 26'($urandom);
    Ready = 1'b1;
    t = 0;
    while (Tx !== 1'b0 && t < 50) begin @(negedge clk); t++; end
    // Sample 0 is the first start-bit cycle; byte1 data bit 3 covers 56..59.
    repeat (57) @(negedge clk);
    Ready = 1'b0;
    bad = 0;
    for (int k = 58; k < 80; k++) begin
      @(negedge clk);
      if (Busy !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL abort_busy_hold: got %0d early-idle cycles required 0", bad); end
    @(negedge clk);
    checks++;
    if (Busy !== 1'b0 || Tx !== 1'b1 || Done !== 1'b0 || WordCount !== 2'd0) begin
      errors++;
      $display("FAIL abort_idle: got Busy=%b Tx=%b Done=%b WC=%0d required 0 1 0 0", Busy, Tx, Done, WordCount);
    end
    bad = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (Tx !== 1'b1 || ReadClock !== 1'b0 || Busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0 || rc_pulses != 1) begin
      errors++;
      $display("FAIL abort_quiet: got %0d active cycles, %0d pulses required 0 and 1", bad, rc_pulses);
    end
    checks++;
    if (rx_q.size() != 2 || rx_stop_err != 0) begin
      errors++;
      $display("FAIL abort_bytes: got %0d bytes, %0d stop errors required 2 and 0", rx_q.size(), rx_stop_err);
    end
    for (int i = 0; i < 2 && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== model_byte(mem[0], i)) begin
        errors++;
        $display("FAIL abort_byte%0d: got %02h required %02h", i, rx_q[i], model_byte(mem[0], i));
      end
    end
  endtask

  task automatic test_bit_timing();
    logic [39:0] exp_bits;
    logic [7:0]  b;
    int bit_err [40];
    int t, w;
    do_reset();
    MemData_def = 26'($urandom);
    for (int i = 0; i < 4; i++) begin
      b = model_byte(MemData_def, i);
      exp_bits[i * 10] = 1'b0;
      for (int k = 0; k < 8; k++) exp_bits[i * 10 + 1 + k] = b[k];
      exp_bits[i * 10 + 9] = 1'b1;
    end
    for (int i = 0; i < 40; i++) bit_err[i] = 0;
    Ready_def = 1'b1;
    t = 0;
    while (ReadClock_def !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    w = 0;
    while (ReadClock_def === 1'b1 && w < 100) begin w++; @(negedge clk); end
    checks++;
    if (w != 3) begin errors++; $display("FAIL timing_rc_width: got %0d required 3", w); end
    t = 0;
    while (Tx_def !== 1'b0 && t < 20) begin @(negedge clk); t++; end
    for (int s = 1; s < DFRAME; s++) begin
      @(negedge clk);
      if (Tx_def !== exp_bits[s / DDIV]) bit_err[s / DDIV]++;
    end
    for (int i = 0; i < 40; i++) begin
      checks++;
      if (bit_err[i] != 0) begin
        errors++;
        $display("FAIL timing_bit%0d: got %0d wrong samples required 0 (level %b for %0d clocks)",
                 i, bit_err[i], exp_bits[i], DDIV);
      end
    end
    @(negedge clk);
    checks++;
    if (Tx_def !== 1'b1 || Busy_def !== 1'b1 || WordCount_def !== 12'd0) begin
      errors++;
      $display("FAIL timing_frame_end: got Tx=%b Busy=%b WC=%0d required 1 1 0", Tx_def, Busy_def, WordCount_def);
    end
    Ready_def = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (Busy_def !== 1'b0 || ReadClock_def !== 1'b0 || WordCount_def !== 12'd0) begin
      errors++;
      $display("FAIL timing_release: got Busy=%b RC=%b WC=%0d required 0 0 0", Busy_def, ReadClock_def, WordCount_def);
    end
  endtask

  initial begin
    Reset = 1'b1;
    Ready = 1'b0;
    Ready_def = 1'b0;
    MemData_def = 26'd0;
    test_reset();
    test_dump(26'h3FFFFFF, 26'h0000001, 26'h1000000, 26'($urandom), "dump_fixed");
    test_dump(26'($urandom), 26'($urandom), 26'($urandom), 26'($urandom), "dump_rand_a");
    test_dump(26'($urandom), 26'($urandom), 26'($urandom), 26'($urandom), "dump_rand_b");
    test_abort_read();
    test_abort_send();
    test_bit_timing();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/isa_capture_uart_dumper.md
Name: isa_capture_uart_dumper

Overview:
- Downstream consumer of the ISA bus capture buffer (4096 x 26-bit records: encoded CS, IO/MEM/16-bit flags, SA[19:0]).
- Waits for the capture stage's Ready flag, then clocks every record out of the buffer read port using ReadClock.
- Streams each record to the host PC over a built-in 8N1 UART transmitter, using a self-synchronising 4-byte frame.

Parameters:
CLK_HZ, 50000000, Clock50MHz frequency in Hz
BAUD, 115200, UART bit rate; DIV = CLK_HZ/BAUD truncated (434 at defaults)
DEPTH, 4096, records per dump; must equal capture buffer depth
AW, 12, word counter width; must satisfy 2^AW >= DEPTH

Ports:
Clock50MHz  in  1  system clock
Reset  in  1  asynchronous, active-high; shared with the capture stage
Ready  in  1  capture buffer full and readable (from capture stage)
MemData  in  26  capture buffer read data q (DataOut of capture stage)
ReadClock  out  1  capture buffer read clock; falling edge advances upstream read address
Tx  out  1  UART serial output, idle high
Busy  out  1  dump in progress
Done  out  1  all DEPTH records sent; held until Ready falls
WordCount  out  AW  index of record currently being sent

Behaviour:
- Reset (async) values: ReadClock=0, Tx=1, Busy=0, Done=0, WordCount=0, state IDLE. Reset mid-byte forces Tx=1 immediately, with no stop-bit completion.
- States: IDLE, RD_HI, LATCH, RD_LO, SEND, NEXT, DONE.
- IDLE: Busy=0. If Ready=1, go to RD_HI with Busy=1.
- Read handshake, cycle-level, with the cycle entering RD_HI = n:
  - n: ReadClock goes 1; the buffer registers the current address.
  - n+2: MemData captured into a 26-bit word register (state LATCH).
  - n+3: ReadClock goes 0 (RD_LO); upstream address increments.
  - Exactly one ReadClock pulse per record. Minimum ReadClock low time between pulses = one full frame.
- Frame encoding, for word register D, sent in this order:
  - byte0 = {1, 0, 0, D[25:21]}
  - byte1 = {0, D[20:14]}
  - byte2 = {0, D[13:7]}
  - byte3 = {0, D[6:0]}
  - Bit 7 of each byte marks start of frame.
- UART:
  - Per byte: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). Each bit lasts exactly DIV clocks.
  - Bytes within a frame are back-to-back: the next start bit follows the stop bit with no idle gap.
  - One byte = 10*DIV clocks.
- NEXT:
  - If WordCount == DEPTH-1, go to DONE.
  - Otherwise increment WordCount and go to RD_HI on the next cycle.
- DONE: Busy=0, Done=1, Tx=1, ReadClock=0. On Ready=0, go to IDLE, with Done=0 and WordCount=0.
- Ready falling in RD_HI/LATCH/RD_LO/SEND/NEXT (abort):
  - Finish the current UART byte, including its stop bit, so Tx never glitches.
  - Drive ReadClock=0, then go to IDLE with WordCount=0, Busy=0, Done=0.
  - If Ready falls while ReadClock=1, drop ReadClock on the next cycle.
- Ready high again while in DONE: no effect; a new dump requires Ready to fall and then rise.
- WordCount wrap: cannot occur; the terminal check happens before any increment.

Test Plan:
1. Assert Reset mid-transmission -> Tx=1, ReadClock=0, Busy=0, Done=0, WordCount=0 within the same cycle (async).
2. Memory model word0=26'h3FFFFFF, Ready=1 -> ReadClock high for exactly 3 cycles; bytes on Tx are 0x9F, 0x7F, 0x7F, 0x7F.
3. Word=26'h0000001 then 26'h1000000 -> frames 0x80,0x00,0x00,0x01 then 0x88,0x00,0x00,0x00.
4. Bit timing at defaults -> start bit low for 434 clocks; data LSB first, 434 clocks per bit; stop bit high; next start bit with no gap; 17360 clocks per frame.
5. DEPTH=4, AW=2, Ready held high -> exactly 4 ReadClock pulses, 16 bytes in address order; Done=1 and Busy=0 the cycle after the last stop bit ends; Ready=0 -> Done=0.
6. Ready dropped during bit 3 of byte1 -> byte1 completes including stop bit; no further bytes or ReadClock pulses; state IDLE, Busy=0.
